// File: rtl/core_pkg.sv
// Shared core types for the vector store path.
//   NrLanes / AddrWidth : default lane count and byte-address width
//   insn_id_t           : vector instruction tag
//   vrf_data_t          : one 64-bit lane operand
//   store_req_t         : store request {id, addr, len (bytes)}
//   vstu_state_e        : vstore_unit FSM states
package core_pkg;

  localparam int unsigned NrLanes   = 4;
  localparam int unsigned AddrWidth = 32;

  typedef logic [3:0]  insn_id_t;
  typedef logic [63:0] vrf_data_t;

  typedef struct packed {
    insn_id_t               id;
    logic [AddrWidth-1:0]   addr;
    logic [15:0]            len;
  } store_req_t;

  typedef enum logic [1:0] {
    VSTU_IDLE,
    VSTU_BUSY,
    VSTU_WAIT_B,
    VSTU_DONE
  } vstu_state_e;

endpackage

// File: rtl/vstore_unit_if.sv
// Bundle of every handshake/bus signal of vstore_unit.
//   store_req_*  : request from vinsn_launcher
//   store_op_*   : per-lane operand streams
//   mem_w_*      : write-beat channel to memory
//   mem_b_*      : write-response channel
//   store_done_* : completion report
// Modports: slave = vstore_unit side, master = launcher/lanes/memory side.
interface vstore_unit_if #(
  parameter int unsigned NrLanes   = core_pkg::NrLanes,
  parameter int unsigned AddrWidth = core_pkg::AddrWidth
);
  import core_pkg::*;

  logic                          store_req_valid_i;
  logic                          store_req_ready_o;
  store_req_t                    store_req_i;

  logic [NrLanes-1:0]            store_op_valid_i;
  logic [NrLanes-1:0]            store_op_ready_o;
  vrf_data_t [NrLanes-1:0]       store_op_i;

  logic                          mem_w_valid_o;
  logic                          mem_w_ready_i;
  logic [AddrWidth-1:0]          mem_w_addr_o;
  logic [NrLanes*64-1:0]         mem_w_data_o;
  logic [NrLanes*8-1:0]          mem_w_strb_o;
  logic                          mem_w_last_o;

  logic                          mem_b_valid_i;
  logic                          mem_b_ready_o;

  logic                          store_done_o;
  insn_id_t                      store_done_id_o;
  logic                          store_done_gnt_i;

  modport slave (
    input  store_req_valid_i, store_req_i, store_op_valid_i, store_op_i,
           mem_w_ready_i, mem_b_valid_i, store_done_gnt_i,
    output store_req_ready_o, store_op_ready_o, mem_w_valid_o, mem_w_addr_o,
           mem_w_data_o, mem_w_strb_o, mem_w_last_o, mem_b_ready_o,
           store_done_o, store_done_id_o
  );

  modport master (
    output store_req_valid_i, store_req_i, store_op_valid_i, store_op_i,
           mem_w_ready_i, mem_b_valid_i, store_done_gnt_i,
    input  store_req_ready_o, store_op_ready_o, mem_w_valid_o, mem_w_addr_o,
           mem_w_data_o, mem_w_strb_o, mem_w_last_o, mem_b_ready_o,
           store_done_o, store_done_id_o
  );

endinterface

// File: rtl/vstu_strb_gen.sv
// Byte-strobe generator for one write beat.
//   i_rem  : bytes still to be written
//   o_strb : all-ones when i_rem >= BeatBytes, else the low i_rem bits set
//   o_last : this beat finishes the transfer (i_rem <= BeatBytes)
module vstu_strb_gen #(
  parameter int unsigned BeatBytes = 32
) (
  input  logic [15:0]          i_rem,
  output logic [BeatBytes-1:0] o_strb,
  output logic                 o_last
);

  always_comb begin
    o_strb = '0;
    for (int unsigned i = 0; i < BeatBytes; i++) begin
      o_strb[i] = (32'(i_rem) > i);
    end
    o_last = (32'(i_rem) <= BeatBytes);
  end

endmodule

// File: rtl/vstore_unit.sv
// Vector store unit: takes one store request at a time, streams the lane
// operands to memory as full-width beats, waits for the write response and
// reports completion to the launcher.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : vstore_unit_if.slave (request, lane operands, mem W/B, done)
module vstore_unit #(
  parameter int unsigned NrLanes   = core_pkg::NrLanes,
  parameter int unsigned AddrWidth = core_pkg::AddrWidth
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  vstore_unit_if.slave  bus
);
  import core_pkg::*;

  localparam int unsigned BeatBytes = NrLanes * 8;

  vstu_state_e          r_state, w_state_next;
  logic [AddrWidth-1:0] r_addr;
  logic [15:0]          r_rem;
  insn_id_t             r_id;

  logic                 w_all_valid;
  logic                 w_valid;
  logic                 w_fire;
  logic                 w_accept;
  logic                 w_req_ready;
  logic                 w_b_ready;
  logic                 w_done;
  logic                 w_last;
  logic [BeatBytes-1:0] w_strb;
  logic [AddrWidth-1:0] w_req_addr;

  assign w_all_valid = &bus.store_op_valid_i;
  // Beat valid comes only from state and lane valids, never from mem_w_ready_i.
  assign w_valid     = (r_state == VSTU_BUSY) & w_all_valid;
  assign w_fire      = w_valid & bus.mem_w_ready_i;
  assign w_accept    = w_req_ready & bus.store_req_valid_i;
  assign w_req_addr  = AddrWidth'(bus.store_req_i.addr);

  vstu_strb_gen #(.BeatBytes(BeatBytes)) u_strb_gen (
    .i_rem  (r_rem),
    .o_strb (w_strb),
    .o_last (w_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= VSTU_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_b_ready    = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      VSTU_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.store_req_valid_i)
          w_state_next = (bus.store_req_i.len == '0) ? VSTU_DONE : VSTU_BUSY;
      end
      VSTU_BUSY: begin
        if (w_fire && w_last) w_state_next = VSTU_WAIT_B;
      end
      VSTU_WAIT_B: begin
        w_b_ready = 1'b1;
        if (bus.mem_b_valid_i) w_state_next = VSTU_DONE;
      end
      VSTU_DONE: begin
        w_done = 1'b1;
        if (bus.store_done_gnt_i) w_state_next = VSTU_IDLE;
      end
      default: w_state_next = VSTU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_id   <= '0;
    end else if (w_accept) begin
      r_id   <= bus.store_req_i.id;
      r_addr <= w_req_addr & ~AddrWidth'(BeatBytes - 1);
      r_rem  <= bus.store_req_i.len;
    end else if (w_fire) begin
      r_addr <= r_addr + AddrWidth'(BeatBytes);
      r_rem  <= (32'(r_rem) > BeatBytes) ? r_rem - 16'(BeatBytes) : '0;
    end
  end

  assign bus.store_req_ready_o = w_req_ready;
  assign bus.store_op_ready_o  = {NrLanes{w_fire}};
  assign bus.mem_w_valid_o     = w_valid;
  assign bus.mem_w_addr_o      = r_addr;
  assign bus.mem_w_data_o      = bus.store_op_i;
  assign bus.mem_w_strb_o      = w_strb;
  // Remaining count is zero outside a transfer, so last is qualified by state.
  assign bus.mem_w_last_o      = (r_state == VSTU_BUSY) & w_last;
  assign bus.mem_b_ready_o     = w_b_ready;
  assign bus.store_done_o      = w_done;
  assign bus.store_done_id_o   = r_id;

endmodule

// File: tb/tb_vstore_unit.sv
module tb_vstore_unit;
  import core_pkg::*;

  localparam int unsigned NL = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned BB = NL * 8;
  localparam int unsigned DW = NL * 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vstore_unit_if #(.NrLanes(NL), .AddrWidth(AW)) vif ();

  vstore_unit #(.NrLanes(NL), .AddrWidth(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (vif.slave)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BB-1:0] strb;
    logic          last;
  } beat_t;

  beat_t        exp_q[$];
  insn_id_t     done_q[$];
  logic [63:0]  lane_q [NL][$];

  int unsigned  vectors = 0;
  int unsigned  errors  = 0;
  logic         req_accepted = 1'b0;
  int unsigned  lane_hold [NL];
  int unsigned  wr_hold  = 0;
  int unsigned  gnt_hold = 0;
  int unsigned  p_ready  = 70;
  logic [NL-1:0] pop_seen;

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    vectors++;
    errors++;
    $display("FAIL %s: event occurred, required none", name);
  endfunction

  function automatic logic [BB-1:0] strb_model(int unsigned rem);
    logic [BB:0] one;
    one = 1;
    if (rem >= BB) return '1;
    return BB'((one << rem) - 1);
  endfunction

  function automatic void check_reset_outputs();
    check("rst_req_ready", vif.store_req_ready_o, 1'b1);
    check("rst_op_ready",  vif.store_op_ready_o,  '0);
    check("rst_w_valid",   vif.mem_w_valid_o,     '0);
    check("rst_w_last",    vif.mem_w_last_o,      '0);
    check("rst_b_ready",   vif.mem_b_ready_o,     '0);
    check("rst_done",      vif.store_done_o,      '0);
    check("rst_done_id",   vif.store_done_id_o,   '0);
    check("rst_w_addr",    vif.mem_w_addr_o,      '0);
    check("rst_w_strb",    vif.mem_w_strb_o,      '0);
  endfunction

  function automatic void flush_model();
    exp_q.delete();
    done_q.delete();
    for (int i = 0; i < NL; i++) lane_q[i].delete();
    req_accepted = 1'b0;
  endfunction

  // Lane, memory and launcher environment: inputs change 1 time unit after
  // the rising edge; pops are taken from what the DUT showed before the edge.
  initial begin
    vif.store_req_valid_i = 1'b0;
    vif.store_req_i       = '0;
    vif.store_op_valid_i  = '0;
    vif.store_op_i        = '0;
    vif.mem_w_ready_i     = 1'b0;
    vif.mem_b_valid_i     = 1'b0;
    vif.store_done_gnt_i  = 1'b0;
    for (int i = 0; i < NL; i++) lane_hold[i] = 0;
    forever begin
      @(negedge clk);
      pop_seen = vif.store_op_ready_o;
      @(posedge clk);
      #1;
      if (wr_hold > 0) begin
        vif.mem_w_ready_i = 1'b0;
        if (vif.mem_w_valid_o) wr_hold--;
      end else begin
        vif.mem_w_ready_i = ($urandom_range(0, 99) < p_ready);
      end
      if (gnt_hold > 0) begin
        vif.store_done_gnt_i = 1'b0;
        if (vif.store_done_o) gnt_hold--;
      end else begin
        vif.store_done_gnt_i = ($urandom_range(0, 99) < 50);
      end
      vif.mem_b_valid_i = ($urandom_range(0, 99) < 40);
      for (int i = 0; i < NL; i++) begin
        if (pop_seen[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
        if (lane_hold[i] > 0) begin
          lane_hold[i]--;
          vif.store_op_valid_i[i] = 1'b0;
        end else if (lane_q[i].size() == 0) begin
          vif.store_op_valid_i[i] = 1'b0;
        end else if (!vif.store_op_valid_i[i]) begin
          vif.store_op_valid_i[i] = ($urandom_range(0, 99) < 80);
        end
        vif.store_op_i[i] = vif.store_op_valid_i[i] ? lane_q[i][0] : {$urandom, $urandom};
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic     prev_stall;
    logic     prev_dwait;
    beat_t    prev_b;
    beat_t    b;
    insn_id_t prev_id;
    logic     exp_valid;
    prev_stall = 1'b0;
    prev_dwait = 1'b0;
    prev_id    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_dwait = 1'b0;
      end else begin
        exp_valid = req_accepted && (exp_q.size() != 0) && (&vif.store_op_valid_i);
        check("w_valid", vif.mem_w_valid_o, exp_valid);
        check("op_ready", vif.store_op_ready_o, {NL{exp_valid && vif.mem_w_ready_i}});
        if (prev_stall) begin
          check("stall_valid", vif.mem_w_valid_o, 1'b1);
          check("stall_addr",  vif.mem_w_addr_o,  prev_b.addr);
          check("stall_data",  vif.mem_w_data_o,  prev_b.data);
          check("stall_strb",  vif.mem_w_strb_o,  prev_b.strb);
        end
        if (vif.mem_w_valid_o && vif.mem_w_ready_i) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_beat");
          end else begin
            b = exp_q.pop_front();
            check("beat_addr", vif.mem_w_addr_o, b.addr);
            check("beat_data", vif.mem_w_data_o, b.data);
            check("beat_strb", vif.mem_w_strb_o, b.strb);
            check("beat_last", vif.mem_w_last_o, b.last);
          end
        end
        if (prev_dwait) begin
          check("dwait_done",      vif.store_done_o,      1'b1);
          check("dwait_id",        vif.store_done_id_o,   prev_id);
          check("dwait_req_ready", vif.store_req_ready_o, 1'b0);
        end
        if (vif.store_done_o && vif.store_done_gnt_i) begin
          if (done_q.size() == 0) fail("unexpected_done");
          else check("done_id", vif.store_done_id_o, done_q.pop_front());
        end
        prev_stall  = vif.mem_w_valid_o && !vif.mem_w_ready_i;
        prev_b.addr = vif.mem_w_addr_o;
        prev_b.data = vif.mem_w_data_o;
        prev_b.strb = vif.mem_w_strb_o;
        prev_dwait  = vif.store_done_o && !vif.store_done_gnt_i;
        prev_id     = vif.store_done_id_o;
      end
    end
  end

  // Called with the DUT idle, away from the rising edge.
  task automatic issue(input insn_id_t id, input logic [AW-1:0] addr, input int unsigned len);
    int unsigned   nb;
    int unsigned   rem;
    int unsigned   n;
    logic [63:0]   w;
    logic [AW-1:0] base;
    beat_t         b;
    nb   = (len + BB - 1) / BB;
    base = addr & ~AW'(BB - 1);
    req_accepted = 1'b0;
    for (int unsigned k = 0; k < nb; k++) begin
      rem    = len - k * BB;
      b.addr = base + AW'(k * BB);
      b.strb = strb_model(rem);
      b.last = (k == nb - 1);
      for (int i = 0; i < NL; i++) begin
        w = {$urandom, $urandom};
        lane_q[i].push_back(w);
        b.data[64*i +: 64] = w;
      end
      exp_q.push_back(b);
    end
    done_q.push_back(id);
    vif.store_req_i.id    = id;
    vif.store_req_i.addr  = addr;
    vif.store_req_i.len   = 16'(len);
    vif.store_req_valid_i = 1'b1;
    @(negedge clk);
    check("req_ready_idle", vif.store_req_ready_o, 1'b1);
    n = 0;
    while (!vif.store_req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!vif.store_req_ready_o) begin
      check("req_accept_timeout", vif.store_req_ready_o, 1'b1);
      vif.store_req_valid_i = 1'b0;
      flush_model();
      return;
    end
    @(posedge clk);
    #1;
    vif.store_req_valid_i = 1'b0;
    req_accepted = 1'b1;
    @(negedge clk);
    check("done_after_accept", vif.store_done_o, (len == 0));
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      check("completion_timeout", 1'b0, 1'b1);
      flush_model();
      rst_n = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_beats_below(input int unsigned lim);
    int unsigned n;
    n = 0;
    while (exp_q.size() >= lim && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() >= lim) check("beat_progress_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #2;

    // Two full beats.
    issue(4'd3, 32'h100, 64);
    wait_done(2000);
    // Partial tail beat, unaligned start address.
    issue(4'd5, 32'h204, 40);
    wait_done(2000);
    // Zero-length request.
    issue(4'd7, 32'h40, 0);
    wait_done(2000);
    // Lane 2 late.
    lane_hold[2] = 5;
    issue(4'd8, 32'h800, 64);
    wait_done(2000);
    // Write backpressure mid-transfer and a held-off grant.
    p_ready  = 100;
    gnt_hold = 4;
    issue(4'd9, 32'h1000, 96);
    wait_beats_below(3);
    wr_hold = 3;
    wait_done(2000);
    p_ready = 70;

    // Reset in the middle of a transfer.
    issue(4'd11, 32'h300, 128);
    wait_beats_below(4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs();
    flush_model();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    issue(4'd12, 32'h500, 72);
    wait_done(2000);

    for (int t = 0; t < 25; t++) begin
      p_ready = $urandom_range(30, 100);
      issue(insn_id_t'($urandom), $urandom, $urandom_range(0, 200));
      wait_done(4000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
